// File: rtl/redis_cache_cmd_queue_regs.sv
// Host register block that stages KEY/DATA words and queues cache commands for the controller.
// Latency: register ack 1 cycle after request; a queued command is presented 1 cycle after its CTRL write.
// Backpressure: cmd_valid_o holds the FIFO head stable until cmd_ready_i; a CTRL write to a full queue is dropped with reg_err_o.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   reg_req_i/we/addr/wdata host register bus request (single-cycle pulse)
//   reg_rdata_o/ack_o/err_o registered bus response, one cycle after the request
//   cmd_valid_o/ready_i     command handshake to the cache controller
//   cmd_op_o/key_o/data_o   command payload (head of the queue)
//   rsp_valid_i/data_i/hit_i controller result, accepted only while waiting on a command
//   irq_o                   completion interrupt (level, registered)
// Optional feature: define REDIS_CACHE_IRQ_EN to build the completion interrupt
// (CTRL[2] irq_en, STATUS[5] irq_pending). Without it irq_o is 0 and those bits read 0.
module redis_cache_cmd_queue_regs #(
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 64,
  parameter int QUEUE_DEPTH = 4,
  localparam int VW     = VALUE_WIDTH / 32,
  localparam int KW     = KEY_WIDTH / 32,
  localparam int ADDR_W = $clog2(4 * (VW + KW + 2))
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_req_i,
  input  logic                   reg_we_i,
  input  logic [ADDR_W-1:0]      reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic [31:0]            reg_rdata_o,
  output logic                   reg_ack_o,
  output logic                   reg_err_o,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic [1:0]             cmd_op_o,
  output logic [KEY_WIDTH-1:0]   cmd_key_o,
  output logic [VALUE_WIDTH-1:0] cmd_data_o,
  input  logic                   rsp_valid_i,
  input  logic [VALUE_WIDTH-1:0] rsp_data_i,
  input  logic                   rsp_hit_i,
  output logic                   irq_o
);

  localparam int PW       = $clog2(QUEUE_DEPTH);
  localparam int CW       = $clog2(QUEUE_DEPTH + 1);
  localparam int WW       = ADDR_W - 2;
  localparam int CTRL_W   = VW + KW;
  localparam int STATUS_W = VW + KW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] data_q, data_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic                   hit_q, hit_d;
  logic [1:0]             last_op_q, last_op_d;
  logic [1:0]             cur_op_q, cur_op_d;
  logic                   ovf_q, ovf_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   cmd_vld_q, cmd_vld_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [1:0]             fifo_op_q   [QUEUE_DEPTH];
  logic [1:0]             fifo_op_d   [QUEUE_DEPTH];
  logic [KEY_WIDTH-1:0]   fifo_key_q  [QUEUE_DEPTH];
  logic [KEY_WIDTH-1:0]   fifo_key_d  [QUEUE_DEPTH];
  logic [VALUE_WIDTH-1:0] fifo_data_q [QUEUE_DEPTH];
  logic [VALUE_WIDTH-1:0] fifo_data_d [QUEUE_DEPTH];

`ifdef REDIS_CACHE_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_pend_q, irq_pend_d;
  logic irq_q, irq_d;
`endif

  logic [WW-1:0] word;
  logic          addr_ok, is_wr, ctrl_wr, status_wr, push_req;
  logic          full, empty, busy, do_push, do_pop, ovf_evt, rsp_take;
  logic          irq_en_rd, irq_pend_rd;
  logic [7:0]    count8;
  logic [31:0]   rd_val;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    key_d       = key_q;
    hit_d       = hit_q;
    last_op_d   = last_op_q;
    cur_op_d    = cur_op_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_op_d   = fifo_op_q;
    fifo_key_d  = fifo_key_q;
    fifo_data_d = fifo_data_q;
    rd_val      = '0;
`ifdef REDIS_CACHE_IRQ_EN
    irq_en_d    = irq_en_q;
    irq_pend_d  = irq_pend_q;
    irq_en_rd   = irq_en_q;
    irq_pend_rd = irq_pend_q;
`else
    irq_en_rd   = 1'b0;
    irq_pend_rd = 1'b0;
`endif

    word      = reg_addr_i[ADDR_W-1:2];
    addr_ok   = (reg_addr_i[1:0] == 2'b00) && (word <= WW'(STATUS_W));
    is_wr     = reg_req_i && reg_we_i && addr_ok;
    ctrl_wr   = is_wr && (word == WW'(CTRL_W));
    status_wr = is_wr && (word == WW'(STATUS_W));
    push_req  = ctrl_wr && (reg_wdata_i[1:0] != 2'b00);

    full     = (count_q == CW'(QUEUE_DEPTH));
    empty    = (count_q == '0);
    busy     = (state_q != S_IDLE) || !empty;
    count8   = 8'(count_q);
    // A full queue rejects the push even if the head pops this same cycle.
    do_push  = push_req && !full;
    ovf_evt  = push_req && full;
    do_pop   = (state_q == S_ISSUE) && cmd_ready_i;
    rsp_take = (state_q == S_WAIT) && rsp_valid_i;

    // Response first so that a same-cycle host DATA write overrides its word.
    if (rsp_take) begin
      data_d    = rsp_data_i;
      hit_d     = rsp_hit_i;
      last_op_d = cur_op_q;
    end

    for (int i = 0; i < VW; i++) begin
      if (is_wr && (word == WW'(i))) data_d[32*i +: 32] = reg_wdata_i;
    end
    for (int j = 0; j < KW; j++) begin
      if (is_wr && (word == WW'(VW + j))) key_d[32*j +: 32] = reg_wdata_i;
    end

`ifdef REDIS_CACHE_IRQ_EN
    if (ctrl_wr) irq_en_d = reg_wdata_i[2];
    if (status_wr && reg_wdata_i[5]) irq_pend_d = 1'b0;
    // A completion in the same cycle as the clear is a new event and wins.
    if (rsp_take) irq_pend_d = 1'b1;
`endif
    if (status_wr && reg_wdata_i[4]) ovf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;

    // The pushed entry uses the staging registers as they stand this cycle.
    if (do_push) begin
      fifo_op_d[wr_ptr_q]   = reg_wdata_i[1:0];
      fifo_key_d[wr_ptr_q]  = key_q;
      fifo_data_d[wr_ptr_q] = data_q;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      cur_op_d = fifo_op_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);

    // Next state looks at count_d so a fresh push is presented the next cycle.
    case (state_q)
      S_IDLE:  if (count_d != '0) state_d = S_ISSUE;
      S_ISSUE: if (do_pop) state_d = S_WAIT;
      S_WAIT:  if (rsp_take) state_d = (count_d != '0) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cmd_vld_d = (state_d == S_ISSUE);

    for (int i = 0; i < VW; i++) begin
      if (word == WW'(i)) rd_val = data_q[32*i +: 32];
    end
    for (int j = 0; j < KW; j++) begin
      if (word == WW'(VW + j)) rd_val = key_q[32*j +: 32];
    end
    if (word == WW'(CTRL_W))   rd_val = {29'b0, irq_en_rd, last_op_q};
    if (word == WW'(STATUS_W)) rd_val = {16'b0, count8, 2'b0, irq_pend_rd, ovf_q,
                                         empty, full, hit_q, busy};

    ack_d   = reg_req_i;
    err_d   = reg_req_i && (!addr_ok || ovf_evt);
    rdata_d = (reg_req_i && !reg_we_i && addr_ok) ? rd_val : 32'b0;
`ifdef REDIS_CACHE_IRQ_EN
    irq_d   = irq_pend_d && irq_en_d;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      key_q     <= '0;
      hit_q     <= 1'b0;
      last_op_q <= 2'b0;
      cur_op_q  <= 2'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cmd_vld_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      // Clearing the storage keeps the command outputs at 0 after reset.
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_op_q[i]   <= 2'b0;
        fifo_key_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
`ifdef REDIS_CACHE_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      key_q       <= key_d;
      hit_q       <= hit_d;
      last_op_q   <= last_op_d;
      cur_op_q    <= cur_op_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_vld_q   <= cmd_vld_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      fifo_op_q   <= fifo_op_d;
      fifo_key_q  <= fifo_key_d;
      fifo_data_q <= fifo_data_d;
`ifdef REDIS_CACHE_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
`endif
    end
  end

  assign reg_rdata_o = rdata_q;
  assign reg_ack_o   = ack_q;
  assign reg_err_o   = err_q;
  assign cmd_valid_o = cmd_vld_q;
  assign cmd_op_o    = fifo_op_q[rd_ptr_q];
  assign cmd_key_o   = fifo_key_q[rd_ptr_q];
  assign cmd_data_o  = fifo_data_q[rd_ptr_q];
`ifdef REDIS_CACHE_IRQ_EN
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
